// File: rtl/jt6295_acc_cic.sv
// ADPCM channel mixer: sums RATE sub-samples per frame, then CIC-interpolates the mix back to cen_sub rate.
// Build option: define JT6295_ACC_SAT_EN to clamp out-of-range output instead of wrapping it.
module jt6295_acc_cic #(
  parameter int INW   = 12,
  parameter int RATE  = 4,
  parameter int N     = 2,
  parameter int M     = 4,
  parameter int AW    = 14,
  parameter int CALCW = 20,
  parameter int SHIFT = 6,
  parameter int OUTW  = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   cen_sub,
  input  logic signed [INW-1:0]  sound_in,
  output logic signed [OUTW-1:0] sound_out,
  output logic                   sample,
  output logic                   ovf
);

  if ((RATE < 2) || (RATE > 16) || ((RATE & (RATE - 1)) != 0)) begin : g_bad_rate
    $error("jt6295_acc_cic: RATE must be a power of 2 in 2..16");
  end
  if (AW < INW + $clog2(RATE)) begin : g_bad_aw
    $error("jt6295_acc_cic: AW too narrow for RATE summed samples");
  end

  logic signed [AW-1:0]    in_ext;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [AW-1:0]    sum_q, sum_d;
  logic signed [CALCW-1:0] dly_q [1:N][0:M-1];
  logic signed [CALCW-1:0] dly_d [1:N][0:M-1];
  logic signed [CALCW-1:0] comb_n;
  logic signed [CALCW-1:0] integ_q [1:N];
  logic signed [CALCW-1:0] integ_d [1:N];
  logic signed [CALCW-1:0] y_full;
  logic [CALCW-OUTW:0]     y_hi;
  logic                    y_ovf;
  logic signed [OUTW-1:0]  y_fit;
  logic signed [OUTW-1:0]  sound_out_q, sound_out_d;
  logic                    sample_q, sample_d;
  logic                    ovf_q, ovf_d;

  assign in_ext = {{(AW-INW){sound_in[INW-1]}}, sound_in};

  always_comb begin
    acc_d = acc_q;
    if (cen_sub) acc_d = cen ? in_ext : acc_q + in_ext;
    // sum_d feeds the combs directly so a new frame total reaches the integrators on this very tick
    sum_d = cen ? acc_q : sum_q;
  end

  always_comb begin
    logic signed [CALCW-1:0] c;
    c     = {{(CALCW-AW){sum_d[AW-1]}}, sum_d};
    dly_d = dly_q;
    for (int k = 1; k <= N; k++) begin
      if (cen) begin
        dly_d[k][0] = c;
        for (int i = 1; i < M; i++) dly_d[k][i] = dly_q[k][i-1];
      end
      c = c - dly_q[k][M-1];
    end
    comb_n = c;
  end

  // Integrators are pipelined: each stage adds the previous stage's registered value.
  always_comb begin
    integ_d = integ_q;
    if (cen_sub) begin
      integ_d[1] = integ_q[1] + (cen ? comb_n : '0);
      for (int k = 2; k <= N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  always_comb begin
    y_full = integ_q[N] >>> SHIFT;
    y_hi   = y_full[CALCW-1:OUTW-1];
    y_ovf  = !((&y_hi) || !(|y_hi));
`ifdef JT6295_ACC_SAT_EN
    if (y_ovf) y_fit = y_full[CALCW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
    else       y_fit = y_full[OUTW-1:0];
`else
    y_fit = y_full[OUTW-1:0];
`endif
    sound_out_d = cen_sub ? y_fit : sound_out_q;
    sample_d    = cen_sub;
    ovf_d       = ovf_q | (cen_sub & y_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sum_q       <= '0;
      sound_out_q <= '0;
      sample_q    <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 1; k <= N; k++) begin
        integ_q[k] <= '0;
        for (int i = 0; i < M; i++) dly_q[k][i] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sound_out_q <= sound_out_d;
      sample_q    <= sample_d;
      ovf_q       <= ovf_d;
      for (int k = 1; k <= N; k++) begin
        integ_q[k] <= integ_d[k];
        for (int i = 0; i < M; i++) dly_q[k][i] <= dly_d[k][i];
      end
    end
  end

  assign sound_out = sound_out_q;
  assign sample    = sample_q;
  assign ovf       = ovf_q;

endmodule
